// File: rtl/sm83_pkg.sv
// Shared SM83 core types and constants for interrupt dispatch.
package sm83_pkg;

  localparam int unsigned N_IRQ_SRC      = 5;
  localparam logic [15:0] IRQ_VEC_BASE   = 16'h0040;
  localparam int unsigned IRQ_VEC_STRIDE = 8;

  typedef logic [2:0] irq_disp_state_t;
  localparam irq_disp_state_t ST_IDLE    = 3'd0;
  localparam irq_disp_state_t ST_WAIT    = 3'd1;
  localparam irq_disp_state_t ST_DEC_SP  = 3'd2;
  localparam irq_disp_state_t ST_PUSH_HI = 3'd3;
  localparam irq_disp_state_t ST_PUSH_LO = 3'd4;
  localparam irq_disp_state_t ST_LOAD_PC = 3'd5;

  // Three bits covers up to seven sources; the all-ones code marks "no source".
  typedef logic [2:0] irq_idx_t;
  localparam irq_idx_t IRQ_NONE = 3'd7;

endpackage

// File: rtl/sm83_irq_prio_enc.sv
// Lowest-bit-first priority encoder over the pending interrupt vector.
module sm83_irq_prio_enc
  import sm83_pkg::*;
#(
  parameter int unsigned N_IRQ = N_IRQ_SRC
) (
  input  logic [N_IRQ-1:0] i_req,
  output irq_idx_t         o_idx,
  output logic             o_valid
);

  // Scan high to low so the lowest set bit is the last assignment to stick.
  always_comb begin
    o_idx   = IRQ_NONE;
    o_valid = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = irq_idx_t'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sm83_irq_dispatch.sv
// SM83 interrupt entry sequencer: clears IME, pushes PC, loads the vector, acks IF.
module sm83_irq_dispatch
  import sm83_pkg::*;
#(
  parameter int unsigned N_IRQ       = N_IRQ_SRC,
  parameter logic [15:0] VEC_BASE    = IRQ_VEC_BASE,
  parameter int unsigned VEC_STRIDE  = IRQ_VEC_STRIDE,
  parameter int unsigned IDLE_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_boundary,
  input  logic             i_ime,
  input  logic [N_IRQ-1:0] i_ie,
  input  logic [N_IRQ-1:0] i_if_flags,
  input  logic [15:0]      i_r_pc,
  input  logic [15:0]      i_r_sp,
  input  logic             i_mem_ack,
  output logic             o_ime_clr,
  output logic             o_wen_sp,
  output logic [15:0]      o_w_sp,
  output logic             o_wen_pc,
  output logic [15:0]      o_w_pc,
  output logic             o_mem_req,
  output logic [15:0]      o_mem_addr,
  output logic [7:0]       o_mem_wdata,
  output logic [N_IRQ-1:0] o_if_clr,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_halt_wake
);

  localparam int unsigned CW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  irq_disp_state_t r_state, w_state_nxt;
  logic [15:0]     r_pc, r_sp;
  irq_idx_t        r_idx;
  logic [CW-1:0]   r_wcnt;

  logic [N_IRQ-1:0] w_pending;
  irq_idx_t         w_enc_idx;
  logic             w_enc_valid;
  logic             w_accept;
  logic [15:0]      w_vec;

  assign w_pending   = i_ie & i_if_flags;
  assign o_halt_wake = |w_pending;
  assign w_accept    = (r_state == ST_IDLE) && i_boundary && i_ime && (|w_pending);
  assign w_vec       = VEC_BASE + 16'(r_idx) * 16'(VEC_STRIDE);

  sm83_irq_prio_enc #(
    .N_IRQ (N_IRQ)
  ) u_prio_enc (
    .i_req   (w_pending),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = ST_WAIT;
      ST_WAIT:    if (r_wcnt == CW'(IDLE_CYCLES - 1)) w_state_nxt = ST_DEC_SP;
      ST_DEC_SP:  w_state_nxt = ST_PUSH_HI;
      ST_PUSH_HI: if (i_mem_ack) w_state_nxt = ST_PUSH_LO;
      ST_PUSH_LO: if (i_mem_ack) w_state_nxt = ST_LOAD_PC;
      ST_LOAD_PC: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_sp    <= '0;
      r_idx   <= IRQ_NONE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        ST_IDLE: begin
          r_wcnt <= '0;
          if (w_accept) r_pc <= i_r_pc;
        end
        ST_WAIT:   r_wcnt <= r_wcnt + CW'(1);
        ST_DEC_SP: r_sp <= i_r_sp - 16'd1;
        ST_PUSH_HI: begin
          // Priority is frozen here; later IF/IE changes cannot retarget the vector.
          if (i_mem_ack) begin
            r_sp  <= r_sp - 16'd1;
            r_idx <= w_enc_valid ? w_enc_idx : IRQ_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ime_clr   = w_accept;
    o_wen_sp    = 1'b0;
    o_w_sp      = '0;
    o_wen_pc    = 1'b0;
    o_w_pc      = '0;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_if_clr    = '0;
    o_done      = 1'b0;
    o_busy      = (r_state != ST_IDLE);
    unique case (r_state)
      ST_DEC_SP: begin
        o_wen_sp = 1'b1;
        o_w_sp   = i_r_sp - 16'd1;
      end
      ST_PUSH_HI: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = r_sp;
        o_mem_wdata = r_pc[15:8];
        o_wen_sp    = i_mem_ack;
        o_w_sp      = i_mem_ack ? (r_sp - 16'd1) : 16'h0000;
      end
      ST_PUSH_LO: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = r_sp;
        o_mem_wdata = r_pc[7:0];
      end
      ST_LOAD_PC: begin
        o_wen_pc = 1'b1;
        o_done   = 1'b1;
        if (r_idx != IRQ_NONE) begin
          o_w_pc   = w_vec;
          o_if_clr = {{(N_IRQ - 1){1'b0}}, 1'b1} << r_idx;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sm83_irq_dispatch.sv
// Directed bench for sm83_irq_dispatch with a small register-file and bus-log model.
module tb_sm83_irq_dispatch;

  logic        clk = 1'b0;
  logic        rst_n, boundary, ime, mem_ack;
  logic [4:0]  ie, if_flags;
  logic [15:0] pc, sp;
  logic        ime_clr, wen_sp, wen_pc, mem_req, busy, done, halt_wake;
  logic [15:0] w_sp, w_pc, mem_addr;
  logic [7:0]  mem_wdata;
  logic [4:0]  if_clr;

  int nerr = 0;
  int nchk = 0;

  // Per-dispatch observations
  int          nwr, lat, bad;
  logic [15:0] wr_addr [4];
  logic [7:0]  wr_data [4];
  logic [15:0] pc_at_done;
  logic [4:0]  ifclr_at_done;
  logic        ime_clr_t;

  always #5 clk = ~clk;

  sm83_irq_dispatch dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_boundary  (boundary),
    .i_ime       (ime),
    .i_ie        (ie),
    .i_if_flags  (if_flags),
    .i_r_pc      (pc),
    .i_r_sp      (sp),
    .i_mem_ack   (mem_ack),
    .o_ime_clr   (ime_clr),
    .o_wen_sp    (wen_sp),
    .o_w_sp      (w_sp),
    .o_wen_pc    (wen_pc),
    .o_w_pc      (w_pc),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_if_clr    (if_clr),
    .o_busy      (busy),
    .o_done      (done),
    .o_halt_wake (halt_wake)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; register-file writes seen before the edge are applied after it.
  task automatic cyc();
    logic        ws, wp;
    logic [15:0] sd, pd;
    ws = wen_sp; sd = w_sp; wp = wen_pc; pd = w_pc;
    @(posedge clk);
    #2;
    if (ws) sp = sd;
    if (wp) pc = pd;
  endtask

  // Runs from the accept cycle (c=0). stall<0: ack held high; else ack after stall req cycles.
  task automatic run(input int stall, input int chg_c, input logic [4:0] new_ie,
                     input int rst_c);
    int          reqcnt;
    logic        held;
    logic [15:0] paddr;
    logic [7:0]  pdata;
    reqcnt = 0; held = 1'b0; paddr = '0; pdata = '0;
    nwr = 0; lat = -1; bad = 0; pc_at_done = 'x; ifclr_at_done = 'x;
    for (int c = 0; c < 40; c++) begin
      if (c == chg_c) begin
        ie  = new_ie;
        ime = 1'b0;
      end
      if (c == rst_c) rst_n = 1'b0;
      mem_ack = (stall < 0) ? 1'b1 : (mem_req && reqcnt >= stall);
      #1;
      if (c == 0) ime_clr_t = ime_clr;
      if (mem_req) begin
        if (held && (mem_addr !== paddr || mem_wdata !== pdata)) bad++;
        if (!mem_ack && wen_sp) bad++;
        paddr = mem_addr; pdata = mem_wdata;
        if (mem_ack) begin
          if (nwr < 4) begin
            wr_addr[nwr] = mem_addr;
            wr_data[nwr] = mem_wdata;
          end
          nwr++;
          reqcnt = 0;
        end else begin
          reqcnt++;
        end
      end
      held = mem_req && !mem_ack;
      if (done) begin
        lat = c; pc_at_done = w_pc; ifclr_at_done = if_clr;
      end
      cyc();
      boundary = 1'b0;
      if (c == rst_c) begin
        mem_ack = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_wen", 32'({wen_sp, wen_pc}), 32'd0);
        rst_n = 1'b1;
        break;
      end
      if (lat >= 0) break;
    end
    mem_ack = 1'b0;
    ime     = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; boundary = 1'b0; ime = 1'b0; mem_ack = 1'b0;
    ie = '0; if_flags = '0; pc = '0; sp = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_outs", 32'({ime_clr, wen_sp, wen_pc, mem_req, done, if_clr}), 32'd0);
    chk("reset_wake", 32'(halt_wake), 32'd0);
    cyc();

    // Baseline: IF=14 -> source 2 wins, vector 0050
    ie = 5'h1F; if_flags = 5'h14; ime = 1'b1; pc = 16'h1234; sp = 16'hFFFE; boundary = 1'b1;
    run(-1, -1, 5'h00, -1);
    chk("base_imeclr", 32'(ime_clr_t), 32'd1);
    chk("base_lat", 32'(lat), 32'd6);
    chk("base_nwr", 32'(nwr), 32'd2);
    chk("base_wr0", {wr_addr[0], 8'h00, wr_data[0]}, 32'hFFFD_0012);
    chk("base_wr1", {wr_addr[1], 8'h00, wr_data[1]}, 32'hFFFC_0034);
    chk("base_sp", 32'(sp), 32'h0000_FFFC);
    chk("base_pc", 32'(pc), 32'h0000_0050);
    chk("base_ifclr", 32'(ifclr_at_done), 32'h04);
    chk("base_idle", 32'(busy), 32'd0);

    // No accept with IME clear, but halt wake still asserted
    ime = 1'b0; ie = 5'h01; if_flags = 5'h01; boundary = 1'b1;
    #1;
    chk("noacc_wake", 32'(halt_wake), 32'd1);
    chk("noacc_outs", 32'({ime_clr, wen_sp, wen_pc, mem_req, busy}), 32'd0);
    cyc();
    boundary = 1'b0;
    #1;
    chk("noacc_busy", 32'(busy), 32'd0);
    chk("noacc_req", 32'(mem_req), 32'd0);

    // Cancel: IE drops (and IME) before PUSH_HI ack -> vector 0000, no IF ack
    ime = 1'b1; ie = 5'h01; if_flags = 5'h01; pc = 16'h2222; sp = 16'hD000; boundary = 1'b1;
    run(-1, 1, 5'h00, -1);
    chk("cancel_lat", 32'(lat), 32'd6);
    chk("cancel_nwr", 32'(nwr), 32'd2);
    chk("cancel_wr1", {wr_addr[1], 8'h00, wr_data[1]}, 32'hCFFE_0022);
    chk("cancel_pc", 32'(pc_at_done), 32'h0000_0000);
    chk("cancel_ifclr", 32'(ifclr_at_done), 32'h00);
    chk("cancel_sp", 32'(sp), 32'h0000_CFFE);

    // Wrap below zero
    ie = 5'h1F; if_flags = 5'h01; pc = 16'hABCD; sp = 16'h0001; boundary = 1'b1;
    run(-1, -1, 5'h00, -1);
    chk("wrap_wr0", {wr_addr[0], 8'h00, wr_data[0]}, 32'h0000_00AB);
    chk("wrap_wr1", {wr_addr[1], 8'h00, wr_data[1]}, 32'hFFFF_00CD);
    chk("wrap_sp", 32'(sp), 32'h0000_FFFF);
    chk("wrap_pc", 32'(pc), 32'h0000_0040);
    chk("wrap_ifclr", 32'(ifclr_at_done), 32'h01);

    // Stall: ack delayed 3 cycles in each push, source 4 -> vector 0060
    ie = 5'h1F; if_flags = 5'h10; pc = 16'h5A3C; sp = 16'h8000; boundary = 1'b1;
    run(3, -1, 5'h00, -1);
    chk("stall_lat", 32'(lat), 32'd12);
    chk("stall_stable", 32'(bad), 32'd0);
    chk("stall_wr0", {wr_addr[0], 8'h00, wr_data[0]}, 32'h7FFF_005A);
    chk("stall_wr1", {wr_addr[1], 8'h00, wr_data[1]}, 32'h7FFE_003C);
    chk("stall_pc", 32'(pc), 32'h0000_0060);
    chk("stall_ifclr", 32'(ifclr_at_done), 32'h10);

    // Reset during PUSH_LO, then a fresh dispatch
    ie = 5'h02; if_flags = 5'h02; pc = 16'h1111; sp = 16'hC000; boundary = 1'b1;
    run(-1, -1, 5'h00, 5);
    chk("rst_nodone", 32'(lat), 32'hFFFF_FFFF);
    ie = 5'h08; if_flags = 5'h08; pc = 16'h7788; sp = 16'hC000; boundary = 1'b1;
    run(-1, -1, 5'h00, -1);
    chk("fresh_lat", 32'(lat), 32'd6);
    chk("fresh_wr0", {wr_addr[0], 8'h00, wr_data[0]}, 32'hBFFF_0077);
    chk("fresh_wr1", {wr_addr[1], 8'h00, wr_data[1]}, 32'hBFFE_0088);
    chk("fresh_sp", 32'(sp), 32'h0000_BFFE);
    chk("fresh_pc", 32'(pc), 32'h0000_0058);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
